// File: rtl/sys_ctrl_seq_if.sv
// Sequencer-to-datapath bus: register file read port, ALU control/result and UART TX handshake.
interface sys_ctrl_seq_if #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR       = 4,
  parameter int unsigned ALU_FUN_WD = 4
);
  logic                   RdEn;
  logic [ADDR-1:0]        Address;
  logic [WIDTH-1:0]       RdData;
  logic                   RdData_Valid;
  logic [WIDTH-1:0]       ALU_A;
  logic [WIDTH-1:0]       ALU_B;
  logic [ALU_FUN_WD-1:0]  ALU_FUN;
  logic                   ALU_EN;
  logic [2*WIDTH-1:0]     ALU_OUT;
  logic                   ALU_OUT_VLD;
  logic [WIDTH-1:0]       TX_P_DATA;
  logic                   TX_D_VLD;
  logic                   TX_BUSY;

  modport master (
    output RdEn, Address, ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD,
    input  RdData, RdData_Valid, ALU_OUT, ALU_OUT_VLD, TX_BUSY
  );

  modport slave (
    input  RdEn, Address, ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD,
    output RdData, RdData_Valid, ALU_OUT, ALU_OUT_VLD, TX_BUSY
  );
endinterface

// File: rtl/sys_ctrl_seq.sv
// System controller sequencer: reads A, B and NUM_CFG config bytes, runs one ALU op per
// config nibble and streams each 2*WIDTH-bit result to the UART, LS byte first.
module sys_ctrl_seq #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR       = 4,
  parameter int unsigned ALU_FUN_WD = 4,
  parameter int unsigned NUM_CFG    = 2,
  parameter int unsigned CFG_BASE   = 2,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           CONTROL_EN,
  sys_ctrl_seq_if.master bus,
  output logic           BUSY,
  output logic           DONE,
  output logic           ERR
);
  localparam int unsigned NUM_OPS = 2 * NUM_CFG;
  localparam int unsigned KW      = $clog2(NUM_OPS + 1);
  localparam int unsigned RW      = $clog2(NUM_CFG + 2);
  localparam int unsigned TW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned LAST_RD = NUM_CFG + 1;

  typedef enum logic [2:0] {
    IDLE, RD, RDW, OP, ALU_W, TX_WAIT, TX_HOLD, FIN
  } state_t;

  state_t             state;
  logic               en_q;
  logic [KW-1:0]      k;
  logic [RW-1:0]      rd_idx;
  logic [TW-1:0]      tmo;
  logic               byte_sel;
  logic [WIDTH-1:0]   cfg [NUM_CFG];
  logic [2*WIDTH-1:0] res;

  logic [WIDTH-1:0]      cfg_cur;
  logic [ALU_FUN_WD-1:0] fun_cur;
  logic [RW-1:0]         rd_nxt;
  logic [ADDR-1:0]       addr_nxt;
  logic                  tmo_hit;

  // Function code for op k: config byte k/2, low nibble on even k, high nibble on odd k.
  always_comb begin
    cfg_cur = '0;
    for (int i = 0; i < int'(NUM_CFG); i++) begin
      if (k[KW-1:1] == (KW-1)'(i)) cfg_cur = cfg[i];
    end
    fun_cur  = k[0] ? cfg_cur[ALU_FUN_WD +: ALU_FUN_WD] : cfg_cur[ALU_FUN_WD-1:0];
    rd_nxt   = rd_idx + RW'(1);
    addr_nxt = (rd_nxt < RW'(2)) ? ADDR'(rd_nxt) : ADDR'(CFG_BASE + 32'(rd_nxt) - 32'd2);
    tmo_hit  = (tmo == TW'(TIMEOUT - 1));
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state         <= IDLE;
      en_q          <= 1'b0;
      k             <= '0;
      rd_idx        <= '0;
      tmo           <= '0;
      byte_sel      <= 1'b0;
      res           <= '0;
      for (int i = 0; i < int'(NUM_CFG); i++) cfg[i] <= '0;
      bus.RdEn      <= 1'b0;
      bus.Address   <= '0;
      bus.ALU_A     <= '0;
      bus.ALU_B     <= '0;
      bus.ALU_FUN   <= '0;
      bus.ALU_EN    <= 1'b0;
      bus.TX_P_DATA <= '0;
      bus.TX_D_VLD  <= 1'b0;
      BUSY          <= 1'b0;
      DONE          <= 1'b0;
      ERR           <= 1'b0;
    end else begin
      en_q       <= CONTROL_EN;
      bus.RdEn   <= 1'b0;
      bus.ALU_EN <= 1'b0;
      DONE       <= 1'b0;
      case (state)
        IDLE: begin
          if (CONTROL_EN && !en_q) begin
            ERR         <= 1'b0;
            BUSY        <= 1'b1;
            k           <= '0;
            rd_idx      <= '0;
            bus.Address <= '0;
            bus.RdEn    <= 1'b1;
            state       <= RD;
          end
        end
        RD: begin
          tmo   <= '0;
          state <= RDW;
        end
        RDW: begin
          if (bus.RdData_Valid) begin
            if (rd_idx == RW'(0)) bus.ALU_A <= bus.RdData;
            if (rd_idx == RW'(1)) bus.ALU_B <= bus.RdData;
            for (int i = 0; i < int'(NUM_CFG); i++) begin
              if (rd_idx == RW'(i + 2)) cfg[i] <= bus.RdData;
            end
            if (rd_idx == RW'(LAST_RD)) begin
              state <= OP;
            end else begin
              rd_idx      <= rd_nxt;
              bus.Address <= addr_nxt;
              bus.RdEn    <= 1'b1;
              state       <= RD;
            end
          end else if (tmo_hit) begin
            ERR   <= 1'b1;
            BUSY  <= 1'b0;
            state <= IDLE;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        OP: begin
          bus.ALU_FUN <= fun_cur;
          bus.ALU_EN  <= 1'b1;
          tmo         <= '0;
          state       <= ALU_W;
        end
        ALU_W: begin
          if (bus.ALU_OUT_VLD) begin
            res      <= bus.ALU_OUT;
            byte_sel <= 1'b0;
            state    <= TX_WAIT;
          end else if (tmo_hit) begin
            ERR   <= 1'b1;
            BUSY  <= 1'b0;
            state <= IDLE;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        TX_WAIT: begin
          if (!bus.TX_BUSY) begin
            bus.TX_D_VLD  <= 1'b1;
            bus.TX_P_DATA <= byte_sel ? res[WIDTH +: WIDTH] : res[WIDTH-1:0];
            state         <= TX_HOLD;
          end
        end
        // TX_BUSY sampled high is the UART's accept of the presented byte.
        TX_HOLD: begin
          if (bus.TX_BUSY) begin
            bus.TX_D_VLD <= 1'b0;
            if (byte_sel) begin
              k     <= k + KW'(1);
              state <= ((32'(k) + 32'd1) < NUM_OPS) ? OP : FIN;
            end else begin
              byte_sel <= 1'b1;
              state    <= TX_WAIT;
            end
          end
        end
        FIN: begin
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sys_ctrl_seq.sv
// Scoreboard bench for sys_ctrl_seq: register file, ALU and UART stubs plus a decoupled monitor.
module tb_sys_ctrl_seq;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned ADDR  = 4;
  localparam int unsigned FW    = 4;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST, CONTROL_EN, BUSY, DONE, ERR;
  logic CONTROL_EN2, BUSY2, DONE2, ERR2;

  sys_ctrl_seq_if #(.WIDTH(WIDTH), .ADDR(ADDR), .ALU_FUN_WD(FW)) bus ();
  sys_ctrl_seq_if #(.WIDTH(WIDTH), .ADDR(ADDR), .ALU_FUN_WD(FW)) bus2 ();

  sys_ctrl_seq #(.WIDTH(WIDTH), .ADDR(ADDR), .ALU_FUN_WD(FW), .NUM_CFG(2),
                 .CFG_BASE(2), .TIMEOUT(64)) dut (
    .CLK(CLK), .RST(RST), .CONTROL_EN(CONTROL_EN), .bus(bus),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR));

  sys_ctrl_seq #(.WIDTH(WIDTH), .ADDR(ADDR), .ALU_FUN_WD(FW), .NUM_CFG(1),
                 .CFG_BASE(2), .TIMEOUT(64)) dut2 (
    .CLK(CLK), .RST(RST), .CONTROL_EN(CONTROL_EN2), .bus(bus2),
    .BUSY(BUSY2), .DONE(DONE2), .ERR(ERR2));

  int checks = 0;
  int errors = 0;

  int exp_fun[$], exp_tx[$], exp_end[$];
  int exp_fun2[$], exp_tx2[$], exp_end2[$];
  int fun_v[4] = '{1, 2, 3, 4};
  int tx_v[8]  = '{8'h19, 8'h01, 8'h19, 8'h02, 8'h19, 8'h03, 8'h19, 8'h04};
  logic [7:0] exp_a = 8'h0D;
  logic [7:0] exp_b = 8'h0C;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT output with empty scoreboard queue at %0t", name, $time);
  endtask

  // Register file stubs: one-cycle read latency.
  logic [7:0] regs [16];
  logic [7:0] regs2 [16];
  always @(posedge CLK) begin
    bus.RdData_Valid <= bus.RdEn;
    if (bus.RdEn) bus.RdData <= regs[bus.Address];
    bus2.RdData_Valid <= bus2.RdEn;
    if (bus2.RdEn) bus2.RdData <= regs2[bus2.Address];
  end

  // ALU stubs: result {4'h0, fun, A+B} two cycles after ALU_EN; alu_on=0 never answers.
  logic       alu_on = 1'b1;
  logic       d1 = 1'b0, d1_2 = 1'b0;
  logic [3:0] fun_l = 4'h0, fun2_l = 4'h0;
  always @(posedge CLK) begin
    d1 <= bus.ALU_EN & alu_on;
    if (bus.ALU_EN) fun_l <= bus.ALU_FUN;
    bus.ALU_OUT_VLD <= d1;
    bus.ALU_OUT     <= {4'h0, fun_l, 8'(bus.ALU_A + bus.ALU_B)};
    d1_2 <= bus2.ALU_EN;
    if (bus2.ALU_EN) fun2_l <= bus2.ALU_FUN;
    bus2.ALU_OUT_VLD <= d1_2;
    bus2.ALU_OUT     <= {4'h0, fun2_l, 8'(bus2.ALU_A + bus2.ALU_B)};
  end

  // UART stub: busy 10 cycles per byte, optional forced busy and delayed accept.
  logic tx_force = 1'b0;
  logic tx_b = 1'b0;
  int   tx_cnt = 0, tx_age = 0, tx_lag = 0, tx2_cnt = 0;
  logic tx_acc;
  assign bus.TX_BUSY = tx_b | tx_force;
  assign tx_acc = bus.TX_D_VLD && !bus.TX_BUSY && (tx_age >= tx_lag);
  always @(posedge CLK) begin
    tx_age <= (bus.TX_D_VLD && !bus.TX_BUSY && !tx_acc) ? tx_age + 1 : 0;
    if (tx_acc) begin
      tx_b <= 1'b1; tx_cnt <= 10;
    end else if (tx_cnt > 1) begin
      tx_cnt <= tx_cnt - 1;
    end else begin
      tx_b <= 1'b0; tx_cnt <= 0;
    end
    if (bus2.TX_D_VLD && !bus2.TX_BUSY) begin
      bus2.TX_BUSY <= 1'b1; tx2_cnt <= 3;
    end else if (tx2_cnt > 1) begin
      tx2_cnt <= tx2_cnt - 1;
    end else begin
      bus2.TX_BUSY <= 1'b0; tx2_cnt <= 0;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an observable event.
  int   cyc = 0, last_en_cyc = 0, alu_en_cnt = 0, run_cnt = 0;
  logic err_q = 1'b0, busy_q = 1'b0, prev_wait = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge CLK) begin
    cyc = cyc + 1;
    if (RST) begin
      if (bus.ALU_EN) begin
        alu_en_cnt++;
        last_en_cyc = cyc;
        if (exp_fun.size() == 0) unexpected("alu_en");
        else check("alu_fun", 64'(bus.ALU_FUN), 64'(exp_fun.pop_front()));
        check("alu_ab", 64'({bus.ALU_A, bus.ALU_B}), 64'({exp_a, exp_b}));
      end
      if (prev_wait)
        check("tx_hold", 64'({bus.TX_D_VLD, bus.TX_P_DATA}), 64'({1'b1, prev_data}));
      if (tx_acc) begin
        if (exp_tx.size() == 0) unexpected("tx_byte");
        else check("tx_byte", 64'(bus.TX_P_DATA), 64'(exp_tx.pop_front()));
      end
      prev_wait = bus.TX_D_VLD && !bus.TX_BUSY && !tx_acc;
      prev_data = bus.TX_P_DATA;
      if (DONE) begin
        if (exp_end.size() == 0) unexpected("done");
        else check("end_kind_done", 64'(0), 64'(exp_end.pop_front()));
        check("done_busy_err", 64'({BUSY, ERR}), 64'(0));
      end
      if (ERR && !err_q) begin
        if (exp_end.size() == 0) unexpected("err");
        else check("end_kind_err", 64'(1), 64'(exp_end.pop_front()));
        check("err_latency", 64'(cyc - last_en_cyc), 64'(64));
        check("err_busy", 64'(BUSY), 64'(0));
      end
      if (BUSY && !busy_q) begin
        run_cnt++;
        check("err_clear_on_start", 64'(ERR), 64'(0));
      end
      if (bus2.ALU_EN) begin
        if (exp_fun2.size() == 0) unexpected("alu_en2");
        else check("alu_fun2", 64'(bus2.ALU_FUN), 64'(exp_fun2.pop_front()));
      end
      if (bus2.TX_D_VLD && !bus2.TX_BUSY) begin
        if (exp_tx2.size() == 0) unexpected("tx_byte2");
        else check("tx_byte2", 64'(bus2.TX_P_DATA), 64'(exp_tx2.pop_front()));
      end
      if (DONE2) begin
        if (exp_end2.size() == 0) unexpected("done2");
        else check("end_kind_done2", 64'(0), 64'(exp_end2.pop_front()));
        check("done2_err", 64'(ERR2), 64'(0));
      end
    end else begin
      prev_wait = 1'b0;
    end
    err_q  = ERR;
    busy_q = BUSY;
  end

  task automatic push_normal();
    for (int i = 0; i < 4; i++) exp_fun.push_back(fun_v[i]);
    for (int i = 0; i < 8; i++) exp_tx.push_back(tx_v[i]);
    exp_end.push_back(0);
  endtask

  task automatic pulse_en();
    @(posedge CLK); #1 CONTROL_EN = 1'b1;
    @(posedge CLK); #1 CONTROL_EN = 1'b0;
  endtask

  task automatic drain(input string name, input int limit);
    int n = 0;
    while ((exp_fun.size() + exp_tx.size() + exp_end.size() + exp_fun2.size() +
            exp_tx2.size() + exp_end2.size() != 0 || BUSY || BUSY2) && n < limit) begin
      @(posedge CLK); #1;
      n++;
    end
    check(name, 64'(n < limit), 64'(1));
  endtask

  function automatic logic [63:0] outs1();
    return 64'({bus.RdEn, bus.Address, bus.ALU_A, bus.ALU_B, bus.ALU_FUN, bus.ALU_EN,
                bus.TX_P_DATA, bus.TX_D_VLD, BUSY, DONE, ERR});
  endfunction

  initial begin
    int base;
    logic viol;
    RST = 1'b0; CONTROL_EN = 1'b0; CONTROL_EN2 = 1'b0;
    for (int i = 0; i < 16; i++) begin regs[i] = 8'h00; regs2[i] = 8'h00; end
    regs[0] = 8'h0D; regs[1] = 8'h0C; regs[2] = 8'h21; regs[3] = 8'h43;
    regs2[0] = 8'h0D; regs2[1] = 8'h0C; regs2[2] = 8'hFF;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_outputs", outs1(), 64'(0));
    check("reset_outputs2", 64'({bus2.RdEn, bus2.ALU_EN, bus2.TX_D_VLD, BUSY2, DONE2, ERR2}), 64'(0));
    RST = 1'b1;

    // Basic run.
    push_normal();
    pulse_en();
    drain("run1_complete", 2000);
    check("run1_count_err", 64'({8'(run_cnt), ERR}), 64'({8'd1, 1'b0}));

    // CONTROL_EN held high: exactly one run, then a re-pulse gives a second identical run.
    push_normal();
    @(posedge CLK); #1 CONTROL_EN = 1'b1;
    repeat (1200) @(posedge CLK);
    #1;
    check("hold_one_run", 64'({8'(run_cnt), BUSY}), 64'({8'd2, 1'b0}));
    check("hold_drained", 64'(exp_fun.size() + exp_tx.size() + exp_end.size()), 64'(0));
    CONTROL_EN = 1'b0;
    push_normal();
    pulse_en();
    drain("repulse_complete", 2000);
    check("repulse_count", 64'(run_cnt), 64'(3));

    // ALU never answers: ERR after 64 cycles, no bytes, no DONE; next run clears ERR.
    alu_on = 1'b0;
    exp_fun.push_back(1);
    exp_end.push_back(1);
    pulse_en();
    drain("timeout_complete", 2000);
    check("timeout_err_sticky", 64'({ERR, BUSY, DONE}), 64'(3'b100));
    alu_on = 1'b1;
    push_normal();
    pulse_en();
    drain("after_timeout_complete", 2000);
    check("after_timeout_err", 64'(ERR), 64'(0));

    // UART busy for 100 cycles before byte 0, then slow accept.
    tx_force = 1'b1;
    tx_lag   = 3;
    push_normal();
    pulse_en();
    viol = 1'b0;
    repeat (100) begin
      @(posedge CLK); #1;
      if (bus.TX_D_VLD) viol = 1'b1;
    end
    check("no_vld_while_busy", 64'(viol), 64'(0));
    tx_force = 1'b0;
    drain("slow_tx_complete", 3000);
    tx_lag = 0;

    // Reset during ALU_W of op 2; late ALU_OUT_VLD must be ignored.
    base = alu_en_cnt;
    exp_fun.push_back(1); exp_fun.push_back(2);
    exp_tx.push_back(8'h19); exp_tx.push_back(8'h01);
    pulse_en();
    for (int n = 0; n < 2000 && alu_en_cnt < base + 2; n++) begin
      @(posedge CLK); #1;
    end
    check("midrun_reached_op2", 64'(alu_en_cnt), 64'(base + 2));
    RST = 1'b0;
    @(posedge CLK); #1;
    check("midrun_reset_outputs", outs1(), 64'(0));
    RST = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    check("midrun_idle", 64'({BUSY, DONE, ERR, bus.TX_D_VLD}), 64'(0));
    check("midrun_queues", 64'(exp_fun.size() + exp_tx.size() + exp_end.size()), 64'(0));
    push_normal();
    pulse_en();
    drain("post_reset_complete", 2000);

    // NUM_CFG=1, cfg0=0xFF.
    exp_fun2.push_back(15); exp_fun2.push_back(15);
    exp_tx2.push_back(8'h19); exp_tx2.push_back(8'h0F);
    exp_tx2.push_back(8'h19); exp_tx2.push_back(8'h0F);
    exp_end2.push_back(0);
    @(posedge CLK); #1 CONTROL_EN2 = 1'b1;
    @(posedge CLK); #1 CONTROL_EN2 = 1'b0;
    drain("numcfg1_complete", 2000);

    repeat (5) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
